// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused for WIDTH cycles, LSB first,
// with a start/done handshake and registered result, carry and signed-overflow flags.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             sum_d;
  logic             carry_d;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;

  // Single full-adder cell; sum bit enters the result from the MSB side.
  always_comb begin
    sum_d             = sh_a_q[0] ^ sh_b_q[0] ^ c_q;
    carry_d           = (sh_a_q[0] & sh_b_q[0]) | (c_q & (sh_a_q[0] ^ sh_b_q[0]));
    result_d          = result_q >> 1;
    result_d[WIDTH-1] = sum_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with mode.
            sh_a_q   <= a;
            sh_b_q   <= mode ? ~b : b;
            c_q      <= mode;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          sh_a_q   <= sh_a_q >> 1;
          sh_b_q   <= sh_b_q >> 1;
          c_q      <= carry_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // c_q is the carry into the MSB at this point.
            carry_out_q <= carry_d;
            overflow_q  <= c_q ^ carry_d;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
